// File: rtl/adc_init_pkg.sv
// Shared types, defaults and the fixed ADC register table for the init sequencer.
package adc_init_pkg;

  localparam int unsigned DEF_NWORDS = 8;
  localparam int unsigned DEF_WORD_W = 24;
  localparam int unsigned TBL_IDX_W  = 3;

  // Sequencer-level states; SEQ_FRAME covers the whole frame handed to the shifter
  typedef enum logic [2:0] {
    SEQ_IDLE,
    SEQ_LOAD,
    SEQ_FRAME,
    SEQ_GAP,
    SEQ_DONE
  } seq_state_e;

  // Bit-level states owned by the serial shifter
  typedef enum logic [2:0] {
    SH_IDLE,
    SH_SETUP,
    SH_SCLK_LO,
    SH_SCLK_HI,
    SH_HOLD
  } sh_state_e;

  // Address[23:16] / data[15:0]; word 0 is the ADC soft reset
  localparam logic [DEF_WORD_W-1:0] INIT_TABLE [DEF_NWORDS] = '{
    24'h000001, 24'h140041, 24'h150000, 24'h160080,
    24'h180020, 24'h0D0000, 24'h170007, 24'hFF0001
  };

  // Index width that stays at least one bit for single-entry ranges
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Down-counter width able to hold the larger of two cycle counts
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/adc_init_if.sv
// Init handshake plus 3-wire ADC serial port bundle.
interface adc_init_if #(
  parameter int unsigned IDX_W = 3
) ();
  logic             adc_init;
  logic             init_done;
  logic             busy;
  logic             adc_csb;
  logic             adc_sclk;
  logic             adc_sdata;
  logic [IDX_W-1:0] word_idx;

  modport master (
    output adc_init,
    input  init_done, busy, adc_csb, adc_sclk, adc_sdata, word_idx
  );

  modport slave (
    input  adc_init,
    output init_done, busy, adc_csb, adc_sclk, adc_sdata, word_idx
  );
endinterface

// File: rtl/adc_init_seq_shifter.sv
// Serialises one word MSB first: CSB low, SCLK half-periods of SCLK_DIV cycles.
module spi_word_shifter
  import adc_init_pkg::*;
#(
  parameter int unsigned WORD_W   = DEF_WORD_W,
  parameter int unsigned SCLK_DIV = 4,
  parameter int unsigned CNT_W    = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [WORD_W-1:0] word_i,
  output logic              done_c,
  output logic              csb_o,
  output logic              sclk_o,
  output logic              sdata_o
);

  localparam int unsigned BIT_W = idx_width(WORD_W);

  sh_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BIT_W-1:0]  bits_q, bits_d;
  logic [WORD_W-1:0] sh_q, sh_d;
  logic              csb_q, csb_d, sclk_q, sclk_d, sdata_q, sdata_d;

  // State, datapath and output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= SH_IDLE;
      cnt_q   <= '0;
      bits_q  <= '0;
      sh_q    <= '0;
      csb_q   <= 1'b1;
      sclk_q  <= 1'b0;
      sdata_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bits_q  <= bits_d;
      sh_q    <= sh_d;
      csb_q   <= csb_d;
      sclk_q  <= sclk_d;
      sdata_q <= sdata_d;
    end
  end

  // Next state; outputs are derived from the next state so they register in step
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bits_d  = bits_q;
    sh_d    = sh_q;
    done_c  = 1'b0;
    case (state_q)
      SH_IDLE: begin
        if (start_i) begin
          state_d = SH_SETUP;
          cnt_d   = CNT_W'(SCLK_DIV - 1);
          bits_d  = BIT_W'(WORD_W - 1);
          sh_d    = word_i;
        end
      end
      SH_SETUP, SH_SCLK_LO: begin
        if (cnt_q == '0) begin
          state_d = (state_q == SH_SETUP) ? SH_SCLK_LO : SH_SCLK_HI;
          cnt_d   = CNT_W'(SCLK_DIV - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      SH_SCLK_HI: begin
        if (cnt_q == '0) begin
          sh_d  = {sh_q[WORD_W-2:0], 1'b0};
          cnt_d = CNT_W'(SCLK_DIV - 1);
          if (bits_q == '0) begin
            state_d = SH_HOLD;
          end else begin
            bits_d  = bits_q - BIT_W'(1);
            state_d = SH_SCLK_LO;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      SH_HOLD: begin
        if (cnt_q == '0) begin
          state_d = SH_IDLE;
          done_c  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = SH_IDLE;
    endcase

    csb_d   = (state_d == SH_IDLE);
    sclk_d  = (state_d == SH_SCLK_HI);
    sdata_d = ((state_d == SH_SETUP) || (state_d == SH_SCLK_LO) || (state_d == SH_SCLK_HI))
              && sh_d[WORD_W-1];
  end

  assign csb_o   = csb_q;
  assign sclk_o  = sclk_q;
  assign sdata_o = sdata_q;

endmodule

// File: rtl/adc_init_seq.sv
// ADC init responder: walks INIT_TABLE over the serial port, then answers INIT_DONE.
module adc_init_seq
  import adc_init_pkg::*;
#(
  parameter int unsigned NWORDS   = DEF_NWORDS,   // at most the table depth
  parameter int unsigned WORD_W   = DEF_WORD_W,
  parameter int unsigned SCLK_DIV = 4,
  parameter int unsigned CSB_GAP  = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  adc_init_if.slave  bus
);

  localparam int unsigned IDX_W = idx_width(NWORDS);
  localparam int unsigned CNT_W = cnt_width(SCLK_DIV, CSB_GAP);

  seq_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] gcnt_q, gcnt_d;
  logic             init_q;
  logic             busy_q, busy_d, done_q, done_d;
  logic             start_c, sh_done_c;
  logic [WORD_W-1:0] word_c;

  // Request sampling, state and output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= SEQ_IDLE;
      idx_q   <= '0;
      gcnt_q  <= '0;
      init_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      gcnt_q  <= gcnt_d;
      init_q  <= bus.adc_init;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Word sequencing, inter-frame gap and request/done handshake
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    gcnt_d  = gcnt_q;
    start_c = 1'b0;
    case (state_q)
      SEQ_IDLE: begin
        if (init_q) begin
          state_d = SEQ_LOAD;
          idx_d   = '0;
        end
      end
      SEQ_LOAD: begin
        start_c = 1'b1;
        state_d = SEQ_FRAME;
      end
      SEQ_FRAME: begin
        if (sh_done_c) begin
          state_d = SEQ_GAP;
          gcnt_d  = CNT_W'(CSB_GAP - 1);
        end
      end
      SEQ_GAP: begin
        // A dropped request is honoured only here, so frames are never cut short
        if (gcnt_q == '0) begin
          if (!init_q) begin
            state_d = SEQ_IDLE;
          end else if (idx_q < IDX_W'(NWORDS - 1)) begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = SEQ_LOAD;
          end else begin
            state_d = SEQ_DONE;
          end
        end else begin
          gcnt_d = gcnt_q - CNT_W'(1);
        end
      end
      SEQ_DONE: begin
        if (!init_q) state_d = SEQ_IDLE;
      end
      default: state_d = SEQ_IDLE;
    endcase

    busy_d = (state_d != SEQ_IDLE) && (state_d != SEQ_DONE);
    done_d = (state_d == SEQ_DONE);
  end

  assign word_c = WORD_W'(INIT_TABLE[TBL_IDX_W'(idx_q)]);

  spi_word_shifter #(
    .WORD_W   (WORD_W),
    .SCLK_DIV (SCLK_DIV),
    .CNT_W    (CNT_W)
  ) u_shifter (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_c),
    .word_i  (word_c),
    .done_c  (sh_done_c),
    .csb_o   (bus.adc_csb),
    .sclk_o  (bus.adc_sclk),
    .sdata_o (bus.adc_sdata)
  );

  assign bus.init_done = done_q;
  assign bus.busy      = busy_q;
  assign bus.word_idx  = idx_q;

endmodule
